// File: rtl/overshoot_gain_scheduler.sv
// Overshoot gain scheduler: reacts to the overshoot detector by lowering kp,
// raising kd and freezing the PID integrator. Once the position error has
// stayed settled long enough, it walks the gains back to their base values.
// All state changes happen only on clk_100k_enable ticks.
module overshoot_gain_scheduler #(
  parameter logic [31:0] KP_BASE       = 32'd1000,
  parameter logic [31:0] KI_BASE       = 32'd50,
  parameter logic [31:0] KD_BASE       = 32'd200,
  parameter logic [31:0] KP_MIN        = 32'd400,
  parameter logic [31:0] KD_MAX        = 32'd500,
  parameter logic [31:0] KP_STEP       = 32'd100,
  parameter logic [31:0] KD_STEP       = 32'd50,
  parameter logic [15:0] STEP_INTERVAL = 16'd8,
  parameter logic [15:0] HOLD_TICKS    = 16'd100,
  parameter logic [31:0] SETTLE_BAND   = 32'd100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_100k_enable,
  input  logic               overshoot_detected,
  input  logic signed [31:0] error_pos,
  output logic        [31:0] kp,
  output logic        [31:0] ki,
  output logic        [31:0] kd,
  output logic               integrator_freeze,
  output logic               gain_update,
  output logic        [1:0]  sched_state
);

  localparam int unsigned GW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_NOMINAL = 2'd0,
    ST_DAMPING = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] kp_q, kp_d;
  logic [GW-1:0] kd_q, kd_d;
  logic [GW-1:0] ki_q, ki_d;
  logic          freeze_q, freeze_d;
  logic          gain_update_q, gain_update_d;
  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  logic [GW-1:0] err_u;
  logic [GW-1:0] abs_err;
  logic          in_band;
  logic [GW-1:0] kp_down, kd_down, kp_up, kd_up;
  logic [GW:0]   kp_floor_sum, kd_raise_sum, kp_raise_sum, kd_floor_sum;
  logic          step_due;
  logic          hold_done;

  // Saturating absolute error and settle-band test; -2^31 maps to 2^31-1.
  always_comb begin
    err_u   = $unsigned(error_pos);
    abs_err = err_u;
    if (err_u == 32'h8000_0000) begin
      abs_err = 32'h7FFF_FFFF;
    end else if (err_u[GW-1]) begin
      abs_err = GW'(~err_u + 32'd1);
    end
    in_band = (abs_err <= SETTLE_BAND);
  end

  // Saturating down (damping) and up (recovery) step candidates, 33-bit sums.
  always_comb begin
    kp_floor_sum = {1'b0, KP_MIN} + {1'b0, KP_STEP};
    kd_raise_sum = {1'b0, kd_q} + {1'b0, KD_STEP};
    kp_raise_sum = {1'b0, kp_q} + {1'b0, KP_STEP};
    kd_floor_sum = {1'b0, KD_BASE} + {1'b0, KD_STEP};
    kp_down = ({1'b0, kp_q} < kp_floor_sum) ? KP_MIN : (kp_q - KP_STEP);
    kd_down = (kd_raise_sum > {1'b0, KD_MAX}) ? KD_MAX : kd_raise_sum[GW-1:0];
    kp_up   = (kp_raise_sum > {1'b0, KP_BASE}) ? KP_BASE : kp_raise_sum[GW-1:0];
    kd_up   = ({1'b0, kd_q} < kd_floor_sum) ? KD_BASE : (kd_q - KD_STEP);
  end

  assign step_due  = (step_cnt_q == STEP_INTERVAL - 16'd1);
  assign hold_done = (hold_cnt_q == HOLD_TICKS - 16'd1);

  // Next-state, counter and gain decisions; only ticks may change anything.
  always_comb begin
    state_d    = state_q;
    kp_d       = kp_q;
    kd_d       = kd_q;
    freeze_d   = freeze_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (clk_100k_enable) begin
      case (state_q)
        ST_NOMINAL, ST_HOLD: begin
          if (overshoot_detected) begin
            state_d    = ST_DAMPING;
            kp_d       = kp_down;
            kd_d       = kd_down;
            freeze_d   = 1'b1;
            step_cnt_d = '0;
          end else if (state_q == ST_HOLD) begin
            if (!in_band) begin
              hold_cnt_d = '0;
            end else if (hold_done) begin
              state_d    = ST_RECOVER;
              step_cnt_d = '0;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 16'd1;
            end
          end
        end
        ST_DAMPING: begin
          if (overshoot_detected) begin
            if (step_due) begin
              kp_d       = kp_down;
              kd_d       = kd_down;
              step_cnt_d = '0;
            end else begin
              step_cnt_d = step_cnt_q + 16'd1;
            end
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            freeze_d   = 1'b0;
          end
        end
        ST_RECOVER: begin
          // A fresh overshoot pre-empts any recovery step due on this tick.
          if (overshoot_detected) begin
            state_d    = ST_DAMPING;
            kp_d       = kp_down;
            kd_d       = kd_down;
            freeze_d   = 1'b1;
            step_cnt_d = '0;
          end else if (step_due) begin
            kp_d       = kp_up;
            kd_d       = kd_up;
            step_cnt_d = '0;
            if ((kp_up == KP_BASE) && (kd_up == KD_BASE)) begin
              state_d = ST_NOMINAL;
            end
          end else begin
            step_cnt_d = step_cnt_q + 16'd1;
          end
        end
        default: state_d = ST_NOMINAL;
      endcase
    end
    gain_update_d = (kp_d != kp_q) || (kd_d != kd_q);
    ki_d          = freeze_d ? '0 : KI_BASE;
  end

  // State, gain and counter registers with asynchronous reset to nominal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_NOMINAL;
      kp_q          <= KP_BASE;
      kd_q          <= KD_BASE;
      ki_q          <= KI_BASE;
      freeze_q      <= 1'b0;
      gain_update_q <= 1'b0;
      step_cnt_q    <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      kp_q          <= kp_d;
      kd_q          <= kd_d;
      ki_q          <= ki_d;
      freeze_q      <= freeze_d;
      gain_update_q <= gain_update_d;
      step_cnt_q    <= step_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign kp                = kp_q;
  assign ki                = ki_q;
  assign kd                = kd_q;
  assign integrator_freeze = freeze_q;
  assign gain_update       = gain_update_q;
  assign sched_state       = state_q;

endmodule

// File: tb/tb_overshoot_gain_scheduler.sv
// Self-checking bench for overshoot_gain_scheduler: a behavioural model
// queues the expected outputs for every driven cycle, compared one clk later.
module tb_overshoot_gain_scheduler;

  localparam longint KP_BASE = 1000, KI_BASE = 50, KD_BASE = 200;
  localparam longint KP_MIN = 400, KD_MAX = 500, KP_STEP = 100, KD_STEP = 50;
  localparam int     STEP_INTERVAL = 8, HOLD_TICKS = 100;
  localparam longint SETTLE_BAND = 100;
  localparam longint NEG_MAX = -64'sd2147483648;

  logic               clk;
  logic               reset;
  logic               clk_100k_enable;
  logic               overshoot_detected;
  logic signed [31:0] error_pos;
  logic        [31:0] kp, ki, kd;
  logic               integrator_freeze;
  logic               gain_update;
  logic        [1:0]  sched_state;

  overshoot_gain_scheduler dut (
    .clk                (clk),
    .reset              (reset),
    .clk_100k_enable    (clk_100k_enable),
    .overshoot_detected (overshoot_detected),
    .error_pos          (error_pos),
    .kp                 (kp),
    .ki                 (ki),
    .kd                 (kd),
    .integrator_freeze  (integrator_freeze),
    .gain_update        (gain_update),
    .sched_state        (sched_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint kp;
    longint ki;
    longint kd;
    longint fr;
    longint gu;
    longint st;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  // Reference model state (0=NOMINAL 1=DAMPING 2=HOLD 3=RECOVER)
  int     m_st;
  longint m_kp, m_kd;
  int     m_fr, m_step, m_hold;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_kp = KP_BASE; m_kd = KD_BASE; m_fr = 0; m_step = 0; m_hold = 0;
  endtask

  task automatic model_down();
    m_kp = (m_kp - KP_STEP < KP_MIN) ? KP_MIN : m_kp - KP_STEP;
    m_kd = (m_kd + KD_STEP > KD_MAX) ? KD_MAX : m_kd + KD_STEP;
  endtask

  task automatic model_tick(input bit en, input bit od, input longint err, output exp_t e);
    longint old_kp, old_kd, a;
    bit     inb;
    old_kp = m_kp; old_kd = m_kd;
    a = (err < 0) ? -err : err;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    inb = (a <= SETTLE_BAND);
    if (en) begin
      if (od && m_st != 1) begin
        model_down(); m_st = 1; m_fr = 1; m_step = 0;
      end else begin
        case (m_st)
          1: begin
            if (od) begin
              if (m_step == STEP_INTERVAL - 1) begin model_down(); m_step = 0; end
              else m_step++;
            end else begin
              m_st = 2; m_hold = 0; m_fr = 0;
            end
          end
          2: begin
            if (!inb) m_hold = 0;
            else if (m_hold == HOLD_TICKS - 1) begin m_st = 3; m_step = 0; m_hold = 0; end
            else m_hold++;
          end
          3: begin
            if (m_step == STEP_INTERVAL - 1) begin
              m_step = 0;
              m_kp = (m_kp + KP_STEP > KP_BASE) ? KP_BASE : m_kp + KP_STEP;
              m_kd = (m_kd - KD_STEP < KD_BASE) ? KD_BASE : m_kd - KD_STEP;
              if (m_kp == KP_BASE && m_kd == KD_BASE) m_st = 0;
            end else m_step++;
          end
          default: ;
        endcase
      end
    end
    e.kp = m_kp;
    e.kd = m_kd;
    e.ki = m_fr ? 0 : KI_BASE;
    e.fr = m_fr;
    e.gu = (m_kp != old_kp || m_kd != old_kd) ? 1 : 0;
    e.st = m_st;
  endtask

  // Drive one clk of stimulus, queue the expectation, compare after the edge.
  task automatic cycle(input bit en, input bit od, input longint err);
    exp_t e;
    clk_100k_enable    = en;
    overshoot_detected = od;
    error_pos          = 32'(err);
    model_tick(en, od, err, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("kp", longint'(kp), e.kp);
      check("ki", longint'(ki), e.ki);
      check("kd", longint'(kd), e.kd);
      check("freeze", longint'(integrator_freeze), e.fr);
      check("gain_update", longint'(gain_update), e.gu);
      check("sched_state", longint'(sched_state), e.st);
    end
  endtask

  task automatic run(input int n, input bit en, input bit od, input longint err);
    for (int i = 0; i < n; i++) cycle(en, od, err);
  endtask

  task automatic expect_now(input string tag, input longint ekp, input longint ekd, input longint est);
    check({tag, "_kp"}, longint'(kp), ekp);
    check({tag, "_kd"}, longint'(kd), ekd);
    check({tag, "_state"}, longint'(sched_state), est);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_kp"}, longint'(kp), KP_BASE);
    check({tag, "_ki"}, longint'(ki), KI_BASE);
    check({tag, "_kd"}, longint'(kd), KD_BASE);
    check({tag, "_freeze"}, longint'(integrator_freeze), 0);
    check({tag, "_gu"}, longint'(gain_update), 0);
    check({tag, "_state"}, longint'(sched_state), 0);
  endtask

  initial begin
    bit     r_od;
    longint r_err;
    int     sel;
    reset = 1'b1; clk_100k_enable = 1'b0; overshoot_detected = 1'b0; error_pos = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;

    // First overshoot tick: immediate down step, freeze, one pulse
    cycle(1, 1, 0);
    expect_now("first_step", 900, 250, 1);
    check("first_step_ki", longint'(ki), 0);
    run(8, 1, 1, 0);
    expect_now("second_step", 800, 300, 1);

    // Asynchronous reset mid-DAMPING, visible before any clk edge
    #3 reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Long overshoot: saturate kp at KP_MIN and kd at KD_MAX
    run(64, 1, 1, 0);
    expect_now("saturated", 400, 500, 1);

    // Settle in band -> RECOVER after exactly HOLD_TICKS in-band ticks
    cycle(1, 0, 50);
    run(99, 1, 0, 50);
    expect_now("hold_99", 400, 500, 2);
    cycle(1, 0, 50);
    expect_now("recover_entry", 400, 500, 3);

    // Out-of-band excursion restarts the hold count
    cycle(1, 1, 50);
    cycle(1, 0, 50);
    run(50, 1, 0, 50);
    cycle(1, 0, 150);
    run(99, 1, 0, 50);
    expect_now("hold_restart", 400, 500, 2);
    cycle(1, 0, 50);
    expect_now("recover_after_excursion", 400, 500, 3);

    // Overshoot on a step tick at saturation: down step wins, no pulse
    run(7, 1, 0, 50);
    cycle(1, 1, 50);
    expect_now("down_wins_sat", 400, 500, 1);
    check("down_wins_sat_gu", longint'(gain_update), 0);

    // Full recovery from saturation back to NOMINAL
    cycle(1, 0, 50);
    run(100, 1, 0, 50);
    run(47, 1, 0, 50);
    expect_now("recover_47", 900, 250, 3);
    cycle(1, 0, 50);
    expect_now("recover_done", 1000, 200, 0);

    // Overshoot on a step tick mid-range: down step instead of up step
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    run(100, 1, 0, 0);
    run(7, 1, 0, 0);
    cycle(1, 1, 0);
    expect_now("down_wins_mid", 800, 300, 1);

    // Most negative error is out of band and clears the hold count
    cycle(1, 0, 0);
    run(30, 1, 0, 0);
    cycle(1, 0, NEG_MAX);
    run(99, 1, 0, 0);
    expect_now("neg_max_hold", 800, 300, 2);

    // Disabled ticks freeze everything, even with overshoot and bad error
    run(20, 0, 1, NEG_MAX);
    expect_now("enable_low", 800, 300, 2);
    cycle(1, 0, 0);
    expect_now("enable_resume", 800, 300, 3);

    // Randomised mix of ticks, overshoot episodes and error values
    r_od = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) r_od = ~r_od;
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      r_err = NEG_MAX;
      else if (sel < 3)  r_err = longint'($urandom_range(101, 5000));
      else               r_err = longint'($urandom_range(0, 200)) - 100;
      cycle($urandom_range(0, 4) != 0, r_od, r_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
